reg_write_arbiter: RTL and testbench



---
 rtl/reg_write_arbiter_pkg.sv | 24 ++
 rtl/reg_write_arbiter_dff.sv | 18 +
 rtl/reg_write_arbiter_rr_pick.sv | 35 +++
 rtl/reg_write_arbiter.sv | 132 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types, default parameters and helpers for reg_write_arbiter and its sub-blocks.
package reg_write_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 8;

    // Largest supported requester count; onehot() is sized for it and callers slice.
    localparam int N_REQ_MAX = 8;
    localparam int IDX_W_MAX = 3;

    function automatic logic [N_REQ_MAX-1:0] onehot(input logic [IDX_W_MAX-1:0] index);
        logic [N_REQ_MAX-1:0] v;
        v        = '0;
        v[index] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_dff.sv
// Single-bit resettable D flip-flop used as the storage cell of the shared register.
module dff_r (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // Storage cell, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             found
);

    logic [PTR_W:0] idx_s;

    // Walk offsets from farthest to nearest so the nearest set bit is the last to overwrite.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx_s  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_s = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx_s >= (PTR_W+1)'(N_REQ)) begin
                idx_s = idx_s - (PTR_W+1)'(N_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (req[idx_s[PTR_W-1:0]]) begin
                winner = idx_s[PTR_W-1:0];
                found  = 1'b1;
            end else begin
                found  = found;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter writing one of N_REQ requesters into a shared register per cycle.
// Optional REG_WRITE_ARBITER_LOCK_EN adds a lock input that keeps the current grant.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
`ifdef REG_WRITE_ARBITER_LOCK_EN
    input  logic                   lock,
`endif
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       grant,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [CNT_W-1:0]       wr_cnt,
    output logic                   busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e               state_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     gidx_q;
    logic [N_REQ-1:0]     grant_q;
    logic                 q_valid_q;
    logic [CNT_W-1:0]     wr_cnt_q;

    logic [PTR_W-1:0]     win_s;
    logic                 found_s;
    logic                 hold_s;
    logic                 load_s;
    logic [WIDTH-1:0]     wsel_s;
    logic [WIDTH-1:0]     q_d;
    logic [WIDTH-1:0]     q_s;
    logic [N_REQ_MAX-1:0] win_oh_s;
    logic [PTR_W-1:0]     ptr_d;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (win_s),
        .found  (found_s)
    );

    // Next-grant helpers and the load mux feeding the shared register.
    always_comb begin
`ifdef REG_WRITE_ARBITER_LOCK_EN
        hold_s = (state_q == GRANT) && lock && req[gidx_q];
`else
        hold_s = 1'b0;
`endif
        load_s   = (state_q == GRANT);
        wsel_s   = wdata[int'(gidx_q)*WIDTH +: WIDTH];
        q_d      = load_s ? wsel_s : q_s;
        win_oh_s = onehot(IDX_W_MAX'(win_s));
        if (win_s == PTR_W'(N_REQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = win_s + PTR_W'(1);
        end
    end

    // Arbitration FSM with registered grant, write strobe and write counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            grant_q   <= '0;
            q_valid_q <= 1'b0;
            wr_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    q_valid_q <= 1'b0;
                    if (found_s) begin
                        state_q <= GRANT;
                        grant_q <= win_oh_s[N_REQ-1:0];
                        gidx_q  <= win_s;
                        ptr_q   <= ptr_d;
                    end else begin
                        grant_q <= '0;
                    end
                end
                GRANT: begin
                    q_valid_q <= 1'b1;
                    wr_cnt_q  <= wr_cnt_q + CNT_W'(1);
                    if (hold_s) begin
                        state_q <= GRANT;
                    end else if (found_s) begin
                        grant_q <= win_oh_s[N_REQ-1:0];
                        gidx_q  <= win_s;
                        ptr_q   <= ptr_d;
                    end else begin
                        state_q <= IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    grant_q   <= '0;
                    q_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // The shared register itself: one resettable flop per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_qbit
        dff_r u_bit (
            .clk   (clk),
            .rst_n (reset_n),
            .d     (q_d[i]),
            .q     (q_s[i])
        );
    end

    assign grant   = grant_q;
    assign q       = q_s;
    assign q_valid = q_valid_q;
    assign wr_cnt  = wr_cnt_q;
    assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomised self-checking bench for reg_write_arbiter against a behavioural round-robin model.
module tb_reg_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int C  = 8;
    localparam int VW = N + W + 1 + C + 1;

    logic           clk     = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req     = '0;
    logic [N*W-1:0] wdata   = '0;
    logic           lock    = 1'b0;
    logic [N-1:0]   grant;
    logic [W-1:0]   q;
    logic           q_valid;
    logic [C-1:0]   wr_cnt;
    logic           busy;

    int tests = 0;
    int fails = 0;

    // Model: index currently granted (-1 = none), next search start, register, counter.
    int m_gidx = -1;
    int m_ptr  = 0;
    int m_q    = 0;
    int m_cnt  = 0;
    bit m_qv   = 1'b0;

    always #5 clk = ~clk;

    reg_write_arbiter #(.N_REQ(N), .WIDTH(W), .CNT_W(C)) dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef REG_WRITE_ARBITER_LOCK_EN
        .lock    (lock),
`endif
        .req     (req),
        .wdata   (wdata),
        .grant   (grant),
        .q       (q),
        .q_valid (q_valid),
        .wr_cnt  (wr_cnt),
        .busy    (busy)
    );

    function automatic bit req_bit(input logic [N-1:0] r, input int i);
        return ((r >> i) & N'(1)) != '0;
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (req_bit(r, (p + k) % N)) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] g;
        g = '0;
        if (m_gidx >= 0) g = N'(1) << m_gidx;
        return {g, W'(m_q), m_qv, C'(m_cnt), (m_gidx >= 0)};
    endfunction

    task automatic m_reset();
        m_gidx = -1;
        m_ptr  = 0;
        m_q    = 0;
        m_cnt  = 0;
        m_qv   = 1'b0;
    endtask

    // One clock edge: update the model from the inputs seen at that edge, then settle.
    task automatic tick();
        int  w;
        bit  keep;
        @(posedge clk);
        keep = 1'b0;
`ifdef REG_WRITE_ARBITER_LOCK_EN
        if (lock && m_gidx >= 0 && req_bit(req, m_gidx)) keep = 1'b1;
`endif
        if (m_gidx >= 0) begin
            m_q   = int'(W'(wdata >> (m_gidx * W)));
            m_qv  = 1'b1;
            m_cnt = (m_cnt + 1) % (1 << C);
        end else begin
            m_qv = 1'b0;
        end
        if (!keep) begin
            w      = pick(req, m_ptr);
            m_gidx = w;
            if (w >= 0) m_ptr = (w + 1) % N;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            req   = N'($urandom);
            wdata = (N*W)'({$urandom, $urandom});
            @(posedge clk);
            #1;
            tests++;
            if ({grant, q, q_valid, wr_cnt, busy} !== '0) begin
                fails++;
                $display("FAIL reset_hold: got %h expected 0", {grant, q, q_valid, wr_cnt, busy});
            end
        end
        #2;
        req     = '0;
        reset_n = 1'b1;
        m_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if ({grant, q, q_valid, wr_cnt, busy} !== exp_vec()) begin
                fails++;
                $display("FAIL reset_release: got %h expected %h", {grant, q, q_valid, wr_cnt, busy}, exp_vec());
            end
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] g_exp;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req   = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            g_exp = N'(1) << (i % N);
            tests++;
            if (grant !== g_exp) begin
                fails++;
                $display("FAIL rotation_grant: got %b expected %b", grant, g_exp);
            end
            tests++;
            if ({grant, q, q_valid, wr_cnt, busy} !== exp_vec()) begin
                fails++;
                $display("FAIL rotation_model: got %h expected %h", {grant, q, q_valid, wr_cnt, busy}, exp_vec());
            end
        end
        req = '0;
        tick();
        tests++;
        if ({q, wr_cnt, q_valid, grant} !== {8'h44, 8'd8, 1'b1, 4'b0000}) begin
            fails++;
            $display("FAIL rotation_end: got q=%h cnt=%0d qv=%b g=%b expected q=44 cnt=8 qv=1 g=0000", q, wr_cnt, q_valid, grant);
        end
        tick();
    endtask

    task automatic test_single();
        wdata = (N*W)'({$urandom, $urandom});
        wdata[2*W +: W] = 8'hA5;
        req = 4'b0100;
        tick();
        tests++;
        if ({grant, busy} !== {4'b0100, 1'b1}) begin
            fails++;
            $display("FAIL single_grant: got g=%b busy=%b expected g=0100 busy=1", grant, busy);
        end
        req = '0;
        tick();
        tests++;
        if ({q, q_valid, grant} !== {8'hA5, 1'b1, 4'b0000}) begin
            fails++;
            $display("FAIL single_write: got q=%h qv=%b g=%b expected q=a5 qv=1 g=0000", q, q_valid, grant);
        end
        tests++;
        if ({grant, q, q_valid, wr_cnt, busy} !== exp_vec()) begin
            fails++;
            $display("FAIL single_model: got %h expected %h", {grant, q, q_valid, wr_cnt, busy}, exp_vec());
        end
        tick();
        tests++;
        if ({q_valid, busy, q} !== {1'b0, 1'b0, 8'hA5}) begin
            fails++;
            $display("FAIL single_idle: got qv=%b busy=%b q=%h expected qv=0 busy=0 q=a5", q_valid, busy, q);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            req   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            wdata = (N*W)'({$urandom, $urandom});
`ifdef REG_WRITE_ARBITER_LOCK_EN
            lock  = ($urandom_range(0, 3) == 0);
`endif
            tick();
            tests++;
            if ({grant, q, q_valid, wr_cnt, busy} !== exp_vec()) begin
                fails++;
                $display("FAIL random_model: cycle %0d got %h expected %h", i, {grant, q, q_valid, wr_cnt, busy}, exp_vec());
            end
        end
        lock = 1'b0;
        req  = '0;
        tick();
        tick();
    endtask

    task automatic test_mid_reset();
        req = 4'b1111;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({grant, q, wr_cnt, busy, q_valid} !== '0) begin
            fails++;
            $display("FAIL midreset_clear: got %h expected 0", {grant, q, wr_cnt, busy, q_valid});
        end
        #2;
        reset_n = 1'b1;
        m_reset();
        req = 4'b1001;
        tick();
        tests++;
        if (grant !== 4'b0001) begin
            fails++;
            $display("FAIL midreset_ptr: got %b expected 0001", grant);
        end
        req = '0;
        tick();
        tests++;
        if ({grant, q, q_valid, wr_cnt, busy} !== exp_vec()) begin
            fails++;
            $display("FAIL midreset_model: got %h expected %h", {grant, q, q_valid, wr_cnt, busy}, exp_vec());
        end
        tick();
    endtask

    task automatic test_counter_wrap();
        int start_cnt;
        int last;
        start_cnt = m_cnt;
        last      = 0;
        for (int i = 0; i < 256; i++) begin
            req   = N'(1) << $urandom_range(0, N - 1);
            wdata = (N*W)'({$urandom, $urandom});
            tick();
            last = int'(W'(wdata >> (m_gidx * W)));
            req  = '0;
            tick();
            tests++;
            if ({grant, q, q_valid, wr_cnt, busy} !== exp_vec()) begin
                fails++;
                $display("FAIL wrap_model: write %0d got %h expected %h", i, {grant, q, q_valid, wr_cnt, busy}, exp_vec());
            end
        end
        tests++;
        if ({wr_cnt, q} !== {C'(start_cnt), W'(last)}) begin
            fails++;
            $display("FAIL wrap_end: got cnt=%0d q=%h expected cnt=%0d q=%h", wr_cnt, q, start_cnt, last);
        end
    endtask

`ifdef REG_WRITE_ARBITER_LOCK_EN
    task automatic test_lock();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        m_reset();
        wdata = {8'h04, 8'h03, 8'h02, 8'h01};
        req   = 4'b0011;
        lock  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (grant !== 4'b0001) begin
                fails++;
                $display("FAIL lock_hold: cycle %0d got %b expected 0001", i, grant);
            end
        end
        lock = 1'b0;
        tick();
        tests++;
        if ({grant, q, wr_cnt} !== {4'b0010, 8'h01, 8'd3}) begin
            fails++;
            $display("FAIL lock_release: got g=%b q=%h cnt=%0d expected g=0010 q=01 cnt=3", grant, q, wr_cnt);
        end
        req = '0;
        tick();
        tick();
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_rotation();
        test_single();
        test_random();
        test_mid_reset();
        test_counter_wrap();
`ifdef REG_WRITE_ARBITER_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
